pot_scan: RTL

POT_SCAN -- requirements
Module: pot_scan

---
 rtl/pot_scan_pkg.sv | 15 +
 rtl/pot_filt.sv | 20 ++
 rtl/pot_scan.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pot_scan_pkg.sv
// Shared types and constants for the pot_scan potentiometer scanner.
package pot_scan_pkg;

    localparam int CH_W = 3;

    localparam logic [6*CH_W-1:0] DEF_CH_MAP = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_t;

endpackage

// File: rtl/pot_filt.sv
// One-slot smoothing datapath: new = old + ((sample - old) >>> 2) once primed.
// Used by pot_scan; with i_prime tied low it is a plain pass-through of the sample.
module pot_filt #(
    parameter int RES_W = 12
) (
    input  logic             i_prime,
    input  logic [RES_W-1:0] i_old,
    input  logic [RES_W-1:0] i_sample,
    output logic [RES_W-1:0] o_new
);

    logic signed [RES_W:0] w_diff;
    logic signed [RES_W:0] w_step;

    assign w_diff = $signed({1'b0, i_sample}) - $signed({1'b0, i_old});
    assign w_step = w_diff >>> 2;
    // The result always lies between old and sample, so RES_W-bit wrap-around is exact.
    assign o_new  = i_prime ? (i_old + w_step[RES_W-1:0]) : i_sample;

endmodule

// File: rtl/pot_scan.sv
// Round-robin potentiometer scanner driving an A2D start/complete handshake.
// Define POT_SCAN_IIR_EN to smooth each slot's result through pot_filt.
module pot_scan
    import pot_scan_pkg::*;
#(
    parameter int                     NUM_CH   = 6,
    parameter int                     RES_W    = 12,
    parameter logic [NUM_CH*CH_W-1:0] CH_MAP   = DEF_CH_MAP,
    parameter int                     SCAN_GAP = 0,
    parameter int                     TO_CYC   = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic                      strt_cnv,
    output logic [CH_W-1:0]           chnnl,
    input  logic                      cnv_cmplt,
    input  logic [15:0]               res,
    output logic [NUM_CH*RES_W-1:0]   pot_data,
    output logic [NUM_CH-1:0]         pot_vld,
    output logic                      scan_done,
    output logic                      timeout,
    output logic                      busy
);

    localparam int              TO_W      = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [7:0]      GAP_LAST  = 8'(SCAN_GAP - 1);
    localparam logic [2:0]      SLOT_LAST = 3'(NUM_CH - 1);
    localparam logic [3:0]      SLOT_NUM  = 4'(NUM_CH);

    state_t             r_state, w_next;
    logic [2:0]         r_ptr, r_slot, w_slot_inc, w_base, w_off, w_sel, w_hi;
    logic [3:0]         w_sum;
    logic [NUM_CH-1:0]  w_rot;
    logic [CH_W-1:0]    r_chnnl;
    logic [CH_W-1:0]    w_map [NUM_CH];
    logic [TO_W-1:0]    r_to_cnt;
    logic [7:0]         r_gap_cnt;
    logic [RES_W-1:0]   r_data [NUM_CH];
    logic [RES_W-1:0]   w_filt;
    logic [NUM_CH-1:0]  r_vld;
    logic               r_done, r_to;
    logic               w_any, w_go, w_cap, w_abort, w_exit, w_gap_end, w_prime;
    logic               w_unused_res;

`ifdef POT_SCAN_IIR_EN
    logic [NUM_CH-1:0]  r_prime;
    assign w_prime = r_prime[r_slot];
`else
    assign w_prime = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        assign w_map[i]                    = CH_MAP[i*CH_W +: CH_W];
        assign pot_data[i*RES_W +: RES_W]  = r_data[i];
    end

    assign w_slot_inc = (r_slot == SLOT_LAST) ? 3'd0 : r_slot + 3'd1;
    assign w_any      = |ch_en;
    assign w_go       = run && w_any;
    assign w_cap      = (r_state == WAIT) && cnv_cmplt;
    assign w_abort    = (r_state == WAIT) && !cnv_cmplt && (r_to_cnt == TO_LAST);
    assign w_exit     = w_cap || w_abort;
    assign w_gap_end  = (r_state == GAP) && (r_gap_cnt == GAP_LAST);
    // Selection leaving WAIT must already see the advanced pointer.
    assign w_base     = (r_state == WAIT) ? w_slot_inc : r_ptr;
    assign w_rot      = NUM_CH'({ch_en, ch_en} >> w_base);
    assign w_sum      = {1'b0, w_base} + {1'b0, w_off};
    assign w_sel      = (w_sum >= SLOT_NUM) ? 3'(w_sum - SLOT_NUM) : w_sum[2:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_off = 3'd0;
        w_hi  = 3'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = 3'(k);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_en[k]) w_hi = 3'(k);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_go) w_next = START;
            START:   w_next = WAIT;
            WAIT: begin
                if (w_exit) begin
                    if (SCAN_GAP != 0) w_next = GAP;
                    else if (w_go)     w_next = START;
                    else               w_next = IDLE;
                end
            end
            GAP:     if (w_gap_end) w_next = w_go ? START : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= 3'd0;
            r_slot    <= 3'd0;
            r_chnnl   <= '0;
            r_to_cnt  <= '0;
            r_gap_cnt <= 8'd0;
            r_vld     <= '0;
            r_done    <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vld   <= w_cap ? (NUM_CH'(1) << r_slot) : '0;
            r_to    <= w_abort;
            r_done  <= w_exit && w_any && (r_slot == w_hi);
            if (w_next == START) begin
                r_slot  <= w_sel;
                r_chnnl <= w_map[w_sel];
            end
            if (w_exit) r_ptr <= w_slot_inc;
            if (r_state == START)     r_to_cnt <= '0;
            else if (r_state == WAIT) r_to_cnt <= r_to_cnt + 1'b1;
            if (w_exit)              r_gap_cnt <= 8'd0;
            else if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 8'd1;
        end
    end

    // NOTE: this result array is reset, unlike a plain RAM, because pot_data must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_data[i] <= '0;
`ifdef POT_SCAN_IIR_EN
            r_prime <= '0;
`endif
        end else if (w_cap) begin
            r_data[r_slot] <= w_filt;
`ifdef POT_SCAN_IIR_EN
            r_prime[r_slot] <= 1'b1;
`endif
        end
    end

    pot_filt #(
        .RES_W    (RES_W)
    ) u_filt (
        .i_prime  (w_prime),
        .i_old    (r_data[r_slot]),
        .i_sample (res[RES_W-1:0]),
        .o_new    (w_filt)
    );

    assign w_unused_res = ^res;
    assign strt_cnv     = (r_state == START);
    assign busy         = (r_state != IDLE);
    assign chnnl        = r_chnnl;
    assign pot_vld      = r_vld;
    assign scan_done    = r_done;
    assign timeout      = r_to;

endmodule
